// File: rtl/router_pkg.sv
// Shared types and helpers for the router output-port arbiter.
package router_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT   = 2'b01,
        S_RELEASE = 2'b10
    } arb_state_t;

    localparam int unsigned DEF_N_PORTS  = 4;
    localparam int unsigned DEF_MAX_HOLD = 64;

    // Widest configuration the round-robin helper supports.
    localparam int unsigned RR_MAX_PORTS = 16;
    localparam int unsigned RR_MAX_PTR_W = 4;

    typedef struct packed {
        logic                    valid;
        logic [RR_MAX_PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req, searching upward from ptr and wrapping at n_ports-1.
    // n_ports must be a power of two no larger than RR_MAX_PORTS.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_MAX_PTR_W-1:0] ptr,
        input int unsigned             n_ports
    );
        rr_pick_t    pick;
        int unsigned k;
        pick = '0;
        for (int unsigned i = 0; i < RR_MAX_PORTS; i++) begin
            k = (32'(ptr) + i) & (n_ports - 1);
            if ((i < n_ports) && !pick.valid && req[k[RR_MAX_PTR_W-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = k[RR_MAX_PTR_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/router_oport_arb_rr_prio_enc.sv
// Round-robin priority stage: rotate requests so ptr lands on bit 0,
// priority-encode the rotated vector, then rotate the index back.
module rr_prio_enc
    import router_pkg::*;
#(
    parameter int unsigned N_PORTS = DEF_N_PORTS,
    parameter int unsigned PTR_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    logic [N_PORTS-1:0] rot;
    rr_pick_t           pick;

    // Rotate right by ptr; index arithmetic wraps naturally on PTR_W bits.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            rot[i] = req[PTR_W'(i) + ptr];
        end
    end

    assign pick  = rr_pick(RR_MAX_PORTS'(rot), '0, N_PORTS);

    // A zero-extended rotated vector can only yield an in-range index; the
    // range qualification keeps the full encoder result meaningful.
    assign valid = pick.valid && ({1'b0, pick.idx} < (RR_MAX_PTR_W + 1)'(N_PORTS));
    assign idx   = pick.idx[PTR_W-1:0] + ptr;

endmodule

// File: rtl/router_oport_arb.sv
// Per-output-port round-robin arbiter. Grants one input for a whole frame,
// releases when the winner's frame ends, then idles one cycle before the
// next arbitration.
// Optional hold watchdog: define ROUTER_OPORT_ARB_TIMEOUT_EN.
module router_oport_arb
    import router_pkg::*;
#(
    parameter int unsigned N_PORTS  = DEF_N_PORTS,
    parameter int unsigned PTR_W    = $clog2(N_PORTS),
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PORTS-1:0] i_req,
    input  logic [N_PORTS-1:0] i_frame,
    output logic [N_PORTS-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_sel,
    output logic               o_busy,
    output logic               o_timeout
);

    if ((N_PORTS < 2) || (N_PORTS > RR_MAX_PORTS) || ((N_PORTS & (N_PORTS - 1)) != 0)) begin : g_bad_n_ports
        $error("router_oport_arb: N_PORTS must be a power of two in 2..16");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("router_oport_arb: MAX_HOLD must be at least 2");
    end

    arb_state_t         state, state_nxt;
    logic [N_PORTS-1:0] gnt_q, gnt_nxt;
    logic [PTR_W-1:0]   sel_q, sel_nxt;
    logic               busy_q, busy_nxt;
    logic [PTR_W-1:0]   rr_ptr, ptr_nxt;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               hold_expired;

    rr_prio_enc #(
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_prio (
        .req   (i_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            gnt_q  <= '0;
            sel_q  <= '0;
            busy_q <= 1'b0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt_q  <= gnt_nxt;
            sel_q  <= sel_nxt;
            busy_q <= busy_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    // Arbitrate in idle, hold through the frame, release for one cycle.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        sel_nxt   = sel_q;
        busy_nxt  = busy_q;
        ptr_nxt   = rr_ptr;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt = S_GRANT;
                    gnt_nxt   = N_PORTS'(1) << pick_idx;
                    sel_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                end
            end
            S_GRANT: begin
                if (!i_frame[sel_q] || hold_expired) begin
                    state_nxt = S_RELEASE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = sel_q + PTR_W'(1);
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

`ifdef ROUTER_OPORT_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic              timeout_q;

    // Hold counter: zero outside S_GRANT so it is clear on entry; saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (state != S_GRANT) begin
            hold_cnt <= '0;
        end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign hold_expired = (hold_cnt >= HOLD_W'(MAX_HOLD - 1));

    // One-cycle pulse when the grant is revoked while the frame is still up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == S_GRANT) && i_frame[sel_q] && hold_expired;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    assign o_gnt  = gnt_q;
    assign o_sel  = sel_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_router_oport_arb.sv
// Scoreboard bench for router_oport_arb: directed scenarios plus randomized
// input-port agents, checked against an event-level arbitration model.
module tb_router_oport_arb;

    localparam int N           = 4;
    localparam int TB_MAX_HOLD = 8;
`ifdef ROUTER_OPORT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] i_req   = '0;
    logic [N-1:0] i_frame = '0;
    logic [N-1:0] o_gnt;
    logic [1:0]   o_sel;
    logic         o_busy;
    logic         o_timeout;

    router_oport_arb #(
        .N_PORTS  (N),
        .MAX_HOLD (TB_MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_frame   (i_frame),
        .o_gnt     (o_gnt),
        .o_sel     (o_sel),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    typedef struct {
        int port;
        int edge_n;
        bit tout;
    } ev_t;

    ev_t          gq[$];
    ev_t          rq[$];
    int           m_edge  = 0;
    int           m_owner = -1;
    int           m_cool  = 0;
    int           m_ptr   = 0;
    int           m_hold  = 0;
    logic [N-1:0] m_gnt   = '0;
    bit           m_tout  = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        bit to;
        ev_t e;
        if (!reset_n) begin
            m_owner = -1; m_cool = 0; m_ptr = 0; m_hold = 0; m_tout = 1'b0;
            gq.delete(); rq.delete();
        end else begin
            m_edge++;
            m_tout = 1'b0;
            if (m_owner < 0) begin
                if (m_cool > 0) begin
                    m_cool--;
                end else if (i_req != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_owner < 0 && i_req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
                    end
                    m_hold = 0;
                    e.port = m_owner; e.edge_n = m_edge; e.tout = 1'b0;
                    gq.push_back(e);
                end
            end else begin
                to = TO_EN && (m_hold == TB_MAX_HOLD - 1) && i_frame[m_owner];
                if (!i_frame[m_owner] || to) begin
                    e.port = m_owner; e.edge_n = m_edge; e.tout = to;
                    rq.push_back(e);
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cool  = 1;
                    m_tout  = to;
                end else begin
                    m_hold++;
                end
            end
        end
        m_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    end

    // ---------------- monitor ----------------
    int glog[$];
    int tout_total = 0;
    bit prev_busy  = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (!reset_n) begin
            prev_busy = 1'b0;
        end else begin
            while (gq.size() > 0 && gq[0].edge_n < m_edge) begin
                vectors++; miscompares++;
                $display("FAIL grant_event: port %0d expected at edge %0d, got no grant", gq[0].port, gq[0].edge_n);
                void'(gq.pop_front());
            end
            while (rq.size() > 0 && rq[0].edge_n < m_edge) begin
                vectors++; miscompares++;
                $display("FAIL release_event: port %0d expected release at edge %0d, got none", rq[0].port, rq[0].edge_n);
                void'(rq.pop_front());
            end
            check("gnt", 32'(o_gnt), 32'(m_gnt));
            check("busy", 32'(o_busy), 32'(m_owner >= 0));
            check("timeout", 32'(o_timeout), 32'(m_tout));
            if (o_busy && !prev_busy) begin
                glog.push_back(int'(o_sel));
                if (gq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL grant_unexpected: got grant to port %0d, expected none", o_sel);
                end else begin
                    e = gq.pop_front();
                    check("grant_sel", 32'(o_sel), 32'(e.port));
                    check("grant_edge", 32'(m_edge), 32'(e.edge_n));
                end
            end
            if (!o_busy && prev_busy) begin
                if (rq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL release_unexpected: got release, expected grant held");
                end else begin
                    e = rq.pop_front();
                    check("release_edge", 32'(m_edge), 32'(e.edge_n));
                    check("release_tout", 32'(o_timeout), 32'(e.tout));
                end
            end
            if (o_timeout) tout_total++;
            prev_busy = o_busy;
        end
    end

    // ---------------- input-port agents ----------------
    bit           act[N];
    bit           seen[N];
    int           remain[N];
    int           shots[N];
    int           len_lo[N];
    int           len_hi[N];
    int           rate     = 100;
    bit           withdraw = 1'b0;
    logic [N-1:0] req_d    = '0;
    logic [N-1:0] frame_d  = '0;

    task automatic agent_step();
        for (int k = 0; k < N; k++) begin
            if (!act[k]) begin
                if (shots[k] > 0 && $urandom_range(0, 99) < rate) begin
                    act[k] = 1'b1; seen[k] = 1'b0; shots[k]--;
                    remain[k]  = $urandom_range(len_lo[k], len_hi[k]);
                    req_d[k]   = 1'b1;
                    frame_d[k] = 1'b1;
                end
            end else begin
                if (o_gnt[k]) begin
                    seen[k] = 1'b1;
                    if (withdraw) req_d[k] = 1'b0;
                end
                if (seen[k]) begin
                    if (remain[k] == 0) begin
                        act[k] = 1'b0; req_d[k] = 1'b0; frame_d[k] = 1'b0;
                    end else begin
                        remain[k]--;
                    end
                end
            end
        end
        i_req   = req_d;
        i_frame = frame_d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        agent_step();
    endtask

    task automatic set_len(input int lo, input int hi);
        for (int k = 0; k < N; k++) begin
            len_lo[k] = lo; len_hi[k] = hi;
        end
    endtask

    task automatic clear_agents();
        for (int k = 0; k < N; k++) begin
            act[k] = 1'b0; seen[k] = 1'b0; remain[k] = 0; shots[k] = 0;
        end
        req_d = '0; frame_d = '0; i_req = '0; i_frame = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_agents();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic bit agents_idle();
        for (int k = 0; k < N; k++) begin
            if (act[k] || shots[k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_quiet(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (agents_idle() && !o_busy) done = 1'b1;
            else tick();
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL wait_quiet: got activity after %0d cycles, expected idle", budget);
        end
        repeat (3) tick();
    endtask

    task automatic wait_gnt(input int port, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            if (o_gnt[port]) done = 1'b1;
            else tick();
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL wait_gnt: got no grant to port %0d within %0d cycles", port, budget);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    // ---------------- directed and random sequences ----------------
    initial begin
        int base;
        int t0;
        set_len(0, 0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_gnt", 32'(o_gnt), 32'h0);
        check("rst_sel", 32'(o_sel), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_timeout", 32'(o_timeout), 32'h0);
        do_reset();

        // Single requester, frame about ten cycles; leaves pointer at 3.
        base = glog.size();
        set_len(9, 9); rate = 100; withdraw = 1'b0;
        shots[2] = 1;
        wait_quiet(200);
        check("single_count", 32'(glog.size() - base), 32'd1);
        check("single_port", 32'(log_at(base)), 32'd2);

        // Pointer at 3 with ports 0 and 3 requesting: 3 wins, then 0.
        base = glog.size();
        set_len(2, 5);
        shots[0] = 1; shots[3] = 1;
        wait_quiet(200);
        check("wrap_first", 32'(log_at(base)), 32'd3);
        check("wrap_second", 32'(log_at(base + 1)), 32'd0);

        // Late requester waits for the current owner's release.
        base = glog.size();
        set_len(8, 8);
        shots[1] = 1;
        wait_gnt(1, 50);
        repeat (2) tick();
        shots[0] = 1;
        wait_quiet(200);
        check("late_first", 32'(log_at(base)), 32'd1);
        check("late_second", 32'(log_at(base + 1)), 32'd0);

        // Reset in the middle of a grant clears the grant immediately.
        set_len(12, 12);
        shots[3] = 1;
        wait_gnt(3, 50);
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_gnt", 32'(o_gnt), 32'h0);
        check("midrst_busy", 32'(o_busy), 32'h0);
        do_reset();
        base = glog.size();
        set_len(1, 3);
        shots[1] = 1; shots[2] = 1;
        wait_quiet(200);
        check("postrst_first", 32'(log_at(base)), 32'd1);
        check("postrst_second", 32'(log_at(base + 1)), 32'd2);

        // Full contention from a fresh pointer: 0,1,2,3,0,...
        do_reset();
        base = glog.size();
        set_len(4, 4);
        for (int k = 0; k < N; k++) shots[k] = 2;
        wait_quiet(400);
        for (int i = 0; i < 5; i++) check("contention_order", 32'(log_at(base + i)), 32'(i % N));

`ifdef ROUTER_OPORT_ARB_TIMEOUT_EN
        // Watchdog revokes a long frame after TB_MAX_HOLD grant cycles.
        do_reset();
        base = glog.size();
        t0   = tout_total;
        len_lo[1] = 20; len_hi[1] = 20;
        len_lo[2] = 3;  len_hi[2] = 3;
        shots[1] = 1; shots[2] = 1;
        wait_quiet(400);
        check("wdog_first", 32'(log_at(base)), 32'd1);
        check("wdog_next", 32'(log_at(base + 1)), 32'd2);
        check("wdog_pulses", 32'(tout_total - t0), 32'd1);
`else
        t0 = tout_total;
        check("no_wdog_pulses", 32'(t0), 32'd0);
`endif

        // Randomized traffic.
        for (int r = 0; r < 20; r++) begin
            int lo;
            rate     = $urandom_range(20, 100);
            withdraw = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) begin
                lo        = $urandom_range(0, 6);
                len_lo[k] = lo;
                len_hi[k] = lo + $urandom_range(0, 14);
                shots[k]  = $urandom_range(0, 4);
            end
            wait_quiet(3000);
        end

        check("grant_queue_drained", 32'(gq.size()), 32'd0);
        check("release_queue_drained", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no completion, expected finish before %0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
